frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Controller that sequences one rock/paper/scissors frame through the FPGA datapath. It runs in the slow_clk domain on the already-debounced Pi clock and data bits. It assembles 24-bit HSV words and issues row-major pixel writes to the filtered-image buffer. When the frame completes, it hands the frame to the classifier over a start/ready + valid handshake, then latches the result onto the breadboard and LED outputs until the next frame begins.

## Interface
- LENGTH, 40, image rows
- WIDTH, 60, image columns
- HSV_BITS, 24, bits per pixel word ({V,S,H}, LSB first)
- TIMEOUT, 4096, slow_clk cycles without a Pi clock edge before a partial frame is abandoned

Ports:
- slow_clk  in  1  block clock
- dbnc_rst  in  1  asynchronous, active-high reset
- dbnc_pi_clk  in  1  debounced Pi serial clock (level, slow_clk-synchronous)
- dbnc_bit  in  1  debounced serial data
- pix_we  out  1  one-cycle pixel write strobe
- pix_row  out  6  row of current write
- pix_col  out  6  column of current write
- pix_hsv  out  24  assembled HSV word
- cls_start  out  1  classify request, held until accepted
- cls_ready  in  1  classifier can accept
- cls_valid  in  1  one-cycle result strobe
- cls_class  in  2  result: 00 rock, 01 paper, 10 scissors, 11 invalid
- breadboard  out  3  active-low class indicator
- LED  out  6  [2:0] one-hot class, [3] busy, [4] frame_err, [5] 0
- busy  out  1  high in RECV/CLASSIFY/WAIT

## Operation
- Edge detect: pclk_q <= dbnc_pi_clk; edge = dbnc_pi_clk & ~pclk_q. On an edge in IDLE/RECV/SHOW, dbnc_bit is written to bit position bit_cnt of the shift word, and bit_cnt increments.
- States:
  - IDLE: waits for an edge, then goes to RECV (that edge's bit is captured).
  - RECV: on the 24th bit, issue pix_we and advance col. col wraps WIDTH-1 -> 0 and increments row. After write (LENGTH-1, WIDTH-1), go to CLASSIFY.
  - CLASSIFY: cls_start=1. Accepted when cls_start & cls_ready in the same cycle, then go to WAIT.
  - WAIT: when cls_valid is seen, latch cls_class and go to SHOW.
  - SHOW: outputs hold. An edge clears row/col/bit_cnt and frame_err, captures bit 0, and goes to RECV.
- Result mapping:
  - 00: LED[2:0]=001, breadboard=110
  - 01: LED[2:0]=010, breadboard=101
  - 10: LED[2:0]=100, breadboard=011
  - 11: LED[2:0]=000, breadboard=000
- Edges arriving in CLASSIFY/WAIT are ignored and set frame_err.
- Timeout: in RECV, an idle counter resets on every edge. When it reaches TIMEOUT-1, drop the partial word and frame, set frame_err, clear row/col/bit_cnt, and go to IDLE. breadboard/LED[2:0] keep the previous result.
- cls_valid outside WAIT is ignored.
- Row/col arithmetic is unsigned 6-bit. Writes never exceed LENGTH*WIDTH per frame.

## Timing
- Reset values (async): state IDLE, pix_we 0, pix_row/pix_col 0, pix_hsv 0, cls_start 0, breadboard 111, LED 000000, busy 0, bit_cnt 0, frame_err 0. Reset mid-frame discards everything immediately.
- Edge latency: dbnc_pi_clk rises before slow_clk edge n. Edge detected in cycle n, bit stored at edge n+1.
- pix_we is registered. It is high for exactly the one cycle after the 24th bit is stored. pix_row/col/hsv are valid in that cycle and pix_col advances the cycle after.
- Last write at cycle k means cls_start=1 from cycle k+1.
- cls_start deasserts the cycle after acceptance.
- cls_valid at cycle m means breadboard/LED update at cycle m+1.
- An edge and a timeout in the same cycle: the edge wins and the counter resets.

## Structure
- Package rps_pkg:
  - LENGTH, WIDTH, HSV_BITS constants
  - cls_e enum (ROCK, PAPER, SCISSORS, INVALID)
  - seq_state_e enum (IDLE, RECV, CLASSIFY, WAIT, SHOW)
  - class-to-breadboard/LED mapping constants
- Sub-module serial_word_rx contains the edge detect, shift register, bit counter, idle/timeout counter and word_valid pulse. The top level holds the FSM, row/col counters and result latch.

## Test plan
- Reset, then stream one 2400-word frame where every word is 0x000000. Expect 2400 pix_we pulses in row-major order, the last one at (39,59) with pix_hsv=0, then cls_start.
- In CLASSIFY, hold cls_ready=0 for 5 cycles, then 1. Expect cls_start held 5 cycles, accepted once, then low.
- Send cls_valid with class 10. Expect breadboard=011, LED=000100 the next cycle, busy=0.
- Stream 100 bits, then stall for TIMEOUT cycles. Expect IDLE, LED[4]=1, no extra pix_we, breadboard unchanged.
- Pulse dbnc_rst mid-word (bit 13 of pixel 500). Expect every output at its reset value. A new frame then writes from (0,0).
- Toggle dbnc_pi_clk while in WAIT. Expect no bits captured, frame_err=1, and a correct result latch once cls_valid arrives.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared constants, enums and result-mapping helpers for the rock/paper/scissors frame path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rps_pkg;

  localparam int LENGTH   = 40;    // image rows
  localparam int WIDTH    = 60;    // image columns
  localparam int HSV_BITS = 24;    // {V,S,H}, received LSB first
  localparam int TIMEOUT  = 4096;  // idle slow_clk cycles before a partial frame is dropped

  typedef enum logic [1:0] {
    ROCK     = 2'b00,
    PAPER    = 2'b01,
    SCISSORS = 2'b10,
    INVALID  = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RECV     = 3'd1,
    CLASSIFY = 3'd2,
    WAIT     = 3'd3,
    SHOW     = 3'd4
  } seq_state_e;

  // LED[2:0] is one-hot; breadboard is active-low (all-ones means nothing lit)
  localparam logic [2:0] LED_ROCK     = 3'b001;
  localparam logic [2:0] LED_PAPER    = 3'b010;
  localparam logic [2:0] LED_SCISSORS = 3'b100;
  localparam logic [2:0] LED_INVALID  = 3'b000;
  localparam logic [2:0] BB_ROCK      = 3'b110;
  localparam logic [2:0] BB_PAPER     = 3'b101;
  localparam logic [2:0] BB_SCISSORS  = 3'b011;
  localparam logic [2:0] BB_INVALID   = 3'b000;
  localparam logic [2:0] BB_RESET     = 3'b111;

  function automatic logic [2:0] cls_to_led(input cls_e c);
    case (c)
      ROCK:     return LED_ROCK;
      PAPER:    return LED_PAPER;
      SCISSORS: return LED_SCISSORS;
      default:  return LED_INVALID;
    endcase
  endfunction

  function automatic logic [2:0] cls_to_bb(input cls_e c);
    case (c)
      ROCK:     return BB_ROCK;
      PAPER:    return BB_PAPER;
      SCISSORS: return BB_SCISSORS;
      default:  return BB_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/serial_word_rx.sv
// Serial-to-word receiver: Pi clock edge detect, LSB-first shift word, bit counter, idle timeout.
// Latency: o_word_vld/o_word_dat are combinational in the cycle the 24th bit edge is seen.
// Backpressure: none; the caller gates capture with i_cap_en, uncaptured edges are lost.
// Ports: slow_clk/dbnc_rst clock+async reset; dbnc_pi_clk/dbnc_bit serial in;
//        i_cap_en store enable, i_restart force bit 0, i_tmo_en run idle counter;
//        o_edge rising edge, o_word_vld/o_word_dat completed word, o_timeout idle expiry.
module serial_word_rx
  import rps_pkg::*;
#(
  parameter int P_TIMEOUT = TIMEOUT
) (
  input  logic                slow_clk,
  input  logic                dbnc_rst,
  input  logic                dbnc_pi_clk,
  input  logic                dbnc_bit,
  input  logic                i_cap_en,
  input  logic                i_restart,
  input  logic                i_tmo_en,
  output logic                o_edge,
  output logic                o_word_vld,
  output logic [HSV_BITS-1:0] o_word_dat,
  output logic                o_timeout
);

  localparam int BW = $clog2(HSV_BITS);
  localparam int TW = $clog2(P_TIMEOUT);

  logic                r_pclk_q;
  logic [HSV_BITS-1:0] r_shift;
  logic [BW-1:0]       r_bit_cnt;
  logic [TW-1:0]       r_idle;

  logic                w_edge;
  logic                w_store;
  logic [BW-1:0]       w_pos;
  logic                w_last;
  logic [HSV_BITS-1:0] w_word;

  assign w_edge  = dbnc_pi_clk & ~r_pclk_q;
  assign w_store = w_edge & i_cap_en;
  // A new frame always starts at bit 0, whatever was left in the counter
  assign w_pos   = i_restart ? '0 : r_bit_cnt;
  assign w_last  = (w_pos == BW'(HSV_BITS - 1));

  // Word including the bit arriving now, so a full word is available without an extra cycle
  always_comb begin
    w_word        = r_shift;
    w_word[w_pos] = dbnc_bit;
  end

  assign o_edge     = w_edge;
  assign o_word_vld = w_store & w_last;
  assign o_word_dat = w_word;
  // An edge in the expiry cycle wins: the frame is still alive
  assign o_timeout  = i_tmo_en & ~w_edge & (r_idle == TW'(P_TIMEOUT - 1));

  always_ff @(posedge slow_clk or posedge dbnc_rst) begin
    if (dbnc_rst) begin
      r_pclk_q  <= 1'b0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_idle    <= '0;
    end else begin
      r_pclk_q <= dbnc_pi_clk;

      if (o_timeout) begin
        r_bit_cnt <= '0;
      end else if (w_store) begin
        r_shift   <= w_word;
        r_bit_cnt <= w_last ? '0 : w_pos + BW'(1);
      end

      if (!i_tmo_en || w_edge || o_timeout) r_idle <= '0;
      else                                  r_idle <= r_idle + TW'(1);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: row-major pixel writes from serial HSV words, classifier handshake, result latch.
// Latency: pix_we one cycle after the 24th bit; cls_start the cycle after the last write; result one cycle after cls_valid.
// Backpressure: cls_start held until cls_ready; Pi edges during CLASSIFY/WAIT are dropped and flag frame_err.
// Ports: slow_clk/dbnc_rst clock+async reset; dbnc_pi_clk/dbnc_bit serial in; pix_* buffer write;
//        cls_start/cls_ready/cls_valid/cls_class classifier; breadboard, LED, busy status.
module frame_sequencer
  import rps_pkg::*;
#(
  parameter int P_LENGTH  = LENGTH,
  parameter int P_WIDTH   = WIDTH,
  parameter int P_TIMEOUT = TIMEOUT
) (
  input  logic                slow_clk,
  input  logic                dbnc_rst,
  input  logic                dbnc_pi_clk,
  input  logic                dbnc_bit,
  output logic                pix_we,
  output logic [5:0]          pix_row,
  output logic [5:0]          pix_col,
  output logic [HSV_BITS-1:0] pix_hsv,
  output logic                cls_start,
  input  logic                cls_ready,
  input  logic                cls_valid,
  input  logic [1:0]          cls_class,
  output logic [2:0]          breadboard,
  output logic [5:0]          LED,
  output logic                busy
);

  seq_state_e          r_state;
  logic                r_pix_we;
  logic [5:0]          r_row;
  logic [5:0]          r_col;
  logic [HSV_BITS-1:0] r_hsv;
  logic                r_frame_err;
  logic [2:0]          r_led_cls;
  logic [2:0]          r_bb;

  logic                w_edge;
  logic                w_word_vld;
  logic [HSV_BITS-1:0] w_word;
  logic                w_timeout;
  logic                w_cap_en;
  logic                w_last_px;

  assign w_cap_en  = (r_state == IDLE) || (r_state == RECV) || (r_state == SHOW);
  assign w_last_px = (r_row == 6'(P_LENGTH - 1)) && (r_col == 6'(P_WIDTH - 1));

  serial_word_rx #(
    .P_TIMEOUT (P_TIMEOUT)
  ) u_rx (
    .slow_clk    (slow_clk),
    .dbnc_rst    (dbnc_rst),
    .dbnc_pi_clk (dbnc_pi_clk),
    .dbnc_bit    (dbnc_bit),
    .i_cap_en    (w_cap_en),
    .i_restart   (r_state == SHOW),
    .i_tmo_en    (r_state == RECV),
    .o_edge      (w_edge),
    .o_word_vld  (w_word_vld),
    .o_word_dat  (w_word),
    .o_timeout   (w_timeout)
  );

  always_ff @(posedge slow_clk or posedge dbnc_rst) begin
    if (dbnc_rst) begin
      r_state     <= IDLE;
      r_pix_we    <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_hsv       <= '0;
      r_frame_err <= 1'b0;
      r_led_cls   <= LED_INVALID;
      r_bb        <= BB_RESET;
    end else begin
      r_pix_we <= w_word_vld;
      if (w_word_vld) r_hsv <= w_word;

      case (r_state)
        IDLE: begin
          if (w_edge) r_state <= RECV;
        end
        RECV: begin
          if (w_timeout) begin
            r_state     <= IDLE;
            r_frame_err <= 1'b1;
            r_row       <= '0;
            r_col       <= '0;
          end else if (r_pix_we) begin
            // Counters step after the write cycle so row/col stay valid alongside pix_we
            if (w_last_px) begin
              r_state <= CLASSIFY;
              r_row   <= '0;
              r_col   <= '0;
            end else if (r_col == 6'(P_WIDTH - 1)) begin
              r_col <= '0;
              r_row <= r_row + 6'd1;
            end else begin
              r_col <= r_col + 6'd1;
            end
          end
        end
        CLASSIFY: begin
          if (w_edge)    r_frame_err <= 1'b1;
          if (cls_ready) r_state     <= WAIT;
        end
        WAIT: begin
          if (w_edge) r_frame_err <= 1'b1;
          if (cls_valid) begin
            r_led_cls <= cls_to_led(cls_e'(cls_class));
            r_bb      <= cls_to_bb(cls_e'(cls_class));
            r_state   <= SHOW;
          end
        end
        SHOW: begin
          if (w_edge) begin
            r_state     <= RECV;
            r_frame_err <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pix_we     = r_pix_we;
  assign pix_row    = r_row;
  assign pix_col    = r_col;
  assign pix_hsv    = r_hsv;
  assign cls_start  = (r_state == CLASSIFY);
  assign busy       = (r_state == RECV) || (r_state == CLASSIFY) || (r_state == WAIT);
  assign breadboard = r_bb;
  assign LED        = {1'b0, r_frame_err, busy, r_led_cls};

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;
  import rps_pkg::*;

  // Reduced image so several whole frames fit in a short run; timeout kept at its real value
  localparam int L   = 4;
  localparam int W   = 6;
  localparam int TMO = 4096;

  logic        slow_clk    = 1'b0;
  logic        dbnc_rst    = 1'b1;
  logic        dbnc_pi_clk = 1'b0;
  logic        dbnc_bit    = 1'b0;
  logic        cls_ready   = 1'b0;
  logic        cls_valid   = 1'b0;
  logic [1:0]  cls_class   = 2'b00;
  logic        pix_we;
  logic [5:0]  pix_row;
  logic [5:0]  pix_col;
  logic [23:0] pix_hsv;
  logic        cls_start;
  logic [2:0]  breadboard;
  logic [5:0]  LED;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int base;

  int          wr_total = 0;
  logic [5:0]  log_row [0:255];
  logic [5:0]  log_col [0:255];
  logic [23:0] log_hsv [0:255];

  always #5 slow_clk = ~slow_clk;

  frame_sequencer #(.P_LENGTH(L), .P_WIDTH(W), .P_TIMEOUT(TMO)) dut (
    .slow_clk    (slow_clk),
    .dbnc_rst    (dbnc_rst),
    .dbnc_pi_clk (dbnc_pi_clk),
    .dbnc_bit    (dbnc_bit),
    .pix_we      (pix_we),
    .pix_row     (pix_row),
    .pix_col     (pix_col),
    .pix_hsv     (pix_hsv),
    .cls_start   (cls_start),
    .cls_ready   (cls_ready),
    .cls_valid   (cls_valid),
    .cls_class   (cls_class),
    .breadboard  (breadboard),
    .LED         (LED),
    .busy        (busy)
  );

  // Record every pixel write for later in-order checking
  always @(negedge slow_clk) begin
    if (pix_we) begin
      log_row[wr_total[7:0]] <= pix_row;
      log_col[wr_total[7:0]] <= pix_col;
      log_hsv[wr_total[7:0]] <= pix_hsv;
      wr_total <= wr_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge slow_clk);
  endtask

  task automatic send_bit(input logic b);
    dbnc_bit    = b;
    dbnc_pi_clk = 1'b1;
    @(negedge slow_clk);
    dbnc_pi_clk = 1'b0;
    @(negedge slow_clk);
  endtask

  task automatic send_word(input logic [23:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(w[i]);
  endtask

  function automatic logic [23:0] pat(input int i, input int seed);
    logic [31:0] v;
    v = 32'h00A5C31E + i * 32'h0013579B + seed * 32'h00ABCDEF;
    return v[23:0];
  endfunction

  task automatic send_frame(input int seed, input bit zero);
    for (int i = 0; i < L * W; i++) send_word(zero ? 24'h0 : pat(i, seed), 24);
  endtask

  task automatic check_writes(input string tag, input int b, input int n, input int seed, input bit zero);
    chk({tag, " write count"}, wr_total - b, n);
    for (int i = 0; i < n; i++) begin
      chk({tag, " row"}, log_row[b + i], i / W);
      chk({tag, " col"}, log_col[b + i], i % W);
      chk({tag, " hsv"}, log_hsv[b + i], zero ? 24'h0 : pat(i, seed));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " pix_we"},     pix_we,     0);
    chk({tag, " pix_row"},    pix_row,    0);
    chk({tag, " pix_col"},    pix_col,    0);
    chk({tag, " pix_hsv"},    pix_hsv,    0);
    chk({tag, " cls_start"},  cls_start,  0);
    chk({tag, " breadboard"}, breadboard, 3'b111);
    chk({tag, " LED"},        LED,        6'b000000);
    chk({tag, " busy"},       busy,       0);
  endtask

  task automatic accept_and_result(input logic [1:0] c);
    cls_ready = 1'b1;
    tick(1);
    cls_ready = 1'b0;
    chk("cls_start drops after accept", cls_start, 0);
    cls_class = c;
    cls_valid = 1'b1;
    tick(1);
    cls_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(2);
    check_reset_vals("por");
    dbnc_rst = 1'b0;
    tick(2);

    // Frame 1: all-zero words
    base = wr_total;
    send_frame(0, 1'b1);
    chk("f1 cls_start cycle after last write", cls_start, 1);
    chk("f1 busy", busy, 1);
    check_writes("f1", base, L * W, 0, 1'b1);

    // Classifier not ready for 5 cycles
    for (int i = 0; i < 5; i++) begin
      chk("f1 cls_start held", cls_start, 1);
      tick(1);
    end
    cls_ready = 1'b1;
    tick(1);
    cls_ready = 1'b0;
    chk("f1 cls_start low after accept", cls_start, 0);
    tick(3);
    chk("f1 cls_start stays low", cls_start, 0);
    chk("f1 busy in WAIT", busy, 1);

    // Result scissors
    cls_class = 2'b10;
    cls_valid = 1'b1;
    tick(1);
    cls_valid = 1'b0;
    chk("scissors breadboard", breadboard, 3'b011);
    chk("scissors LED", LED, 6'b000100);
    chk("scissors busy", busy, 0);

    // cls_valid in SHOW is ignored
    cls_class = 2'b00;
    cls_valid = 1'b1;
    tick(1);
    cls_valid = 1'b0;
    tick(1);
    chk("stray valid breadboard", breadboard, 3'b011);
    chk("stray valid LED", LED, 6'b000100);

    // Frame 2: patterned words, started by an edge in SHOW
    base = wr_total;
    send_frame(1, 1'b0);
    chk("f2 cls_start", cls_start, 1);
    check_writes("f2", base, L * W, 1, 1'b0);
    cls_ready = 1'b1;
    tick(1);
    cls_ready = 1'b0;
    chk("f2 immediate accept", cls_start, 0);

    // Pi edges while waiting for the result
    base = wr_total;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("wait edges frame_err", LED[4], 1);
    chk("wait edges busy", busy, 1);
    chk("wait edges no writes", wr_total - base, 0);
    cls_class = 2'b01;
    cls_valid = 1'b1;
    tick(1);
    cls_valid = 1'b0;
    chk("paper breadboard", breadboard, 3'b101);
    chk("paper LED with frame_err", LED, 6'b010010);

    // Frame 3: 100 bits then stall past the timeout
    base = wr_total;
    for (int i = 0; i < 4; i++) send_word(pat(i, 2), 24);
    send_word(pat(4, 2), 4);
    chk("f3 frame_err cleared", LED[4], 0);
    chk("f3 busy", busy, 1);
    tick(3990);
    chk("f3 busy before timeout", busy, 1);
    tick(200);
    chk("timeout busy", busy, 0);
    chk("timeout frame_err", LED[4], 1);
    chk("timeout LED class kept", LED[2:0], 3'b010);
    chk("timeout breadboard kept", breadboard, 3'b101);
    check_writes("f3", base, 4, 2, 1'b0);

    // Frame 4 from IDLE, reset in the middle of a word
    base = wr_total;
    for (int i = 0; i < 10; i++) send_word(pat(i, 3), 24);
    send_word(pat(10, 3), 13);
    check_writes("f4", base, 10, 3, 1'b0);
    dbnc_rst = 1'b1;
    tick(1);
    check_reset_vals("mid-frame rst");
    dbnc_rst = 1'b0;
    tick(1);

    // Frame 5 after reset: writes start at (0,0); invalid class
    base = wr_total;
    send_frame(4, 1'b0);
    chk("f5 cls_start", cls_start, 1);
    check_writes("f5", base, L * W, 4, 1'b0);
    accept_and_result(2'b11);
    chk("invalid breadboard", breadboard, 3'b000);
    chk("invalid LED", LED, 6'b000000);

    // Frame 6: rock
    base = wr_total;
    send_frame(5, 1'b0);
    chk("f6 cls_start", cls_start, 1);
    check_writes("f6", base, L * W, 5, 1'b0);
    accept_and_result(2'b00);
    chk("rock breadboard", breadboard, 3'b110);
    chk("rock LED", LED, 6'b000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
